// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1:4 stream demux with select or round-robin routing
module demux1to4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [1:0]       rr_ptr
);
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       tgt;
  logic             accept;
  // route, accept, drain and pointer advance for the next edge
  always_comb begin
    tgt      = rr_mode ? ptr_q : in_sel;
    in_ready = ~valid_q[tgt] | out_ready[tgt];
    accept   = in_valid & in_ready;
    valid_d  = valid_q & ~out_ready;
    data_d   = data_q;
    if (accept) begin
      valid_d[tgt] = 1'b1;
      data_d[tgt]  = in_data;
    end
    ptr_d = !rr_mode ? 2'd0 : accept ? ptr_q + 2'd1 : ptr_q;
  end
  // holding registers and pointer; reset drops every held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign rr_ptr    = rr_mode ? ptr_q : 2'd0;
endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed and random checks against a channel-level model
module tb_demux1to4_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = '0;
  logic [7:0] in_data = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] rr_ptr;
  int checks = 0;
  int errors = 0;
  bit         mv [4];
  logic [7:0] md [4];
  int         mp;

  demux1to4_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] od(input int c);
    return c == 0 ? out_data0 : c == 1 ? out_data1 : c == 2 ? out_data2 : out_data3;
  endfunction

  function automatic logic [3:0] mvalid();
    return {mv[3], mv[2], mv[1], mv[0]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mv[c] = 1'b0;
      md[c] = 8'h00;
    end
    mp = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_out_valid"}, out_valid, mvalid());
    for (int c = 0; c < 4; c++) chk($sformatf("%s_data%0d", tag, c), od(c), md[c]);
  endtask

  task automatic cycle(input bit mode, input bit v, input logic [1:0] sel,
                       input logic [7:0] d, input logic [3:0] rdy, input string tag);
    int  t;
    bit  rdy_exp, acc;
    rr_mode = mode; in_valid = v; in_sel = sel; in_data = d; out_ready = rdy;
    #1;
    t = mode ? mp : int'(sel);
    rdy_exp = !mv[t] || rdy[t];
    acc = v && rdy_exp;
    chk({tag, "_in_ready"}, in_ready, rdy_exp);
    chk({tag, "_rr_ptr"}, rr_ptr, mode ? mp : 0);
    @(posedge clk);
    for (int c = 0; c < 4; c++) if (mv[c] && rdy[c]) mv[c] = 1'b0;
    if (acc) begin
      mv[t] = 1'b1;
      md[t] = d;
    end
    mp = !mode ? 0 : acc ? (mp + 1) % 4 : mp;
    #1;
    check_regs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_rr_ptr", rr_ptr, 2'd0);
    chk("rst_data2", out_data2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    // single word routed by select, then drained
    cycle(0, 1, 2'd2, 8'hA1, 4'hF, "t1_send");
    chk("t1_valid", out_valid, 4'b0100);
    chk("t1_data2", out_data2, 8'hA1);
    cycle(0, 0, 2'd0, 8'h00, 4'hF, "t1_idle");
    chk("t1_drained", out_valid, 4'b0000);
    // back-pressure on channel 1, then simultaneous drain and load
    cycle(0, 1, 2'd1, 8'h11, 4'b1101, "t2_first");
    cycle(0, 1, 2'd1, 8'h22, 4'b1101, "t2_blocked");
    chk("t2_blocked_in_ready", in_ready, 1'b0);
    chk("t2_held", out_data1, 8'h11);
    cycle(0, 1, 2'd1, 8'h22, 4'hF, "t2_swap");
    chk("t2_valid1", out_valid[1], 1'b1);
    chk("t2_data1", out_data1, 8'h22);
    // stalled channel does not block another channel
    cycle(0, 1, 2'd3, 8'h33, 4'b1101, "t3");
    chk("t3_data3", out_data3, 8'h33);
    chk("t3_data1", out_data1, 8'h22);
    cycle(0, 0, 2'd0, 8'h00, 4'hF, "t3_flush");
    // round-robin de-interleave
    for (int i = 0; i < 5; i++) cycle(1, 1, 2'd3, 8'h10 * (i + 1), 4'hF, $sformatf("t4_w%0d", i));
    chk("t4_valid", out_valid, 4'b0001);
    chk("t4_data0", out_data0, 8'h50);
    chk("t4_ptr", rr_ptr, 2'd1);
    // pointer stall on a busy channel
    for (int i = 0; i < 6; i++) cycle(1, 1, 2'd0, 8'h61 + i, 4'b1011, $sformatf("t5_w%0d", i));
    chk("t5_stall_ptr", rr_ptr, 2'd2);
    chk("t5_stall_ready", in_ready, 1'b0);
    chk("t5_stall_data2", out_data2, 8'h62);
    cycle(1, 1, 2'd0, 8'h66, 4'b1011, "t5_still");
    cycle(1, 1, 2'd0, 8'h66, 4'hF, "t5_release");
    chk("t5_data2", out_data2, 8'h66);
    chk("t5_ptr_after", rr_ptr, 2'd3);
    // mode toggle restarts the sequence at channel 0
    cycle(0, 0, 2'd0, 8'h00, 4'hF, "tog0");
    cycle(1, 1, 2'd3, 8'h77, 4'hF, "tog1");
    chk("tog_data0", out_data0, 8'h77);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 5), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            8'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
    // fill all channels with pointer at 1, then reset asynchronously
    cycle(0, 0, 2'd0, 8'h00, 4'hF, "t6_flush");
    for (int i = 0; i < 4; i++) cycle(1, 1, 2'd0, 8'hC0 + i, 4'h0, $sformatf("t6_fill%0d", i));
    cycle(1, 1, 2'd0, 8'hC4, 4'b0001, "t6_rot");
    chk("t6_full", out_valid, 4'hF);
    chk("t6_ptr1", rr_ptr, 2'd1);
    out_ready = 4'h0; in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", out_valid, 4'h0);
    chk("t6_async_ptr", rr_ptr, 2'd0);
    chk("t6_async_data0", out_data0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 2'd2, 8'h99, 4'hF, "t6_post");
    chk("t6_post_data0", out_data0, 8'h99);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
